alu_responder: RTL
==================

// Module: alu_responder
// PURPOSE
//  Command responder between uart_rx (AXI-stream master) and uart_tx (AXI-stream slave).
//  Consumes host command frames byte by byte, executes a 32-bit ALU op, streams the response.
//  Frame: [opcode][rsvd][len_lo][len_hi][payload]; len = total bytes incl. 4-byte header.
// PARAMETERS
//  OP_ECHO   8'hEC  payload echoed back unchanged
//  OP_ADD    8'hA1  sum of all 32-bit LE operands, mod 2^32
//  OP_MUL    8'hB2  product of all 32-bit LE operands, mod 2^32
//  ERR_BYTE  8'hEE  single response byte for rejected frames
// PORTS
//  clk            in   1  system clock
//  rst            in   1  asynchronous, active-low reset
//  s_axis_tdata   in   8  command byte from uart_rx
//  s_axis_tvalid  in   1  command byte valid
//  s_axis_tready  out  1  command byte accepted when valid&ready
//  m_axis_tdata   out  8  response byte to uart_tx
//  m_axis_tvalid  out  1  response byte valid
//  m_axis_tready  in   1  uart_tx accepts byte
//  busy           out  1  high in any state other than OPC
//  err_o          out  1  one-cycle pulse when a frame is rejected
// BEHAVIOUR
//  Reset: async, active-low; state=OPC; all outputs 0 except s_axis_tready=1; accum, counters 0.
//  rst asserted mid-frame: partial frame discarded; no response emitted after release.
//  Handshakes: transfer on valid&ready only. m_axis_tdata/tvalid registered; once tvalid=1,
//   tdata held stable until m_axis_tready. Never drop tvalid without a handshake.
//  States:
//   OPC    latch opcode -> RSV
//   RSV    discard byte -> LLO
//   LLO    latch len[7:0] -> LHI
//   LHI    latch len[15:8]; rem = len-4; dispatch:
//          len<4 -> ERR; ECHO -> ECHO (rem=0 -> OPC); ADD/MUL with rem>=4, rem%4==0 -> OPND,
//          accum = 0 (ADD) or 1 (MUL); all else -> DRAIN
//   ECHO   s_axis_tready = !m_axis_tvalid | m_axis_tready; each accepted byte loaded into
//          output reg next cycle; rem--; rem==0 -> OPC. One-cycle latency per byte.
//   OPND   shift 4 bytes LSB-first into opnd; on 4th byte -> EXEC; rem -= 4
//   EXEC   1 cycle, s_axis_tready=0: accum = accum+opnd or accum*opnd (low 32 bits);
//          rem==0 -> SEND else -> OPND
//   SEND   emit accum[7:0],[15:8],[23:16],[31:24]; after 4th handshake -> OPC
//   DRAIN  accept and discard rem bytes (rem==0 -> ERR)
//   ERR    emit ERR_BYTE once; err_o pulses on entry; after handshake -> OPC
//  s_axis_tready=0 in EXEC, SEND, ERR and while output reg full in ECHO.
//  len field 0xFFFF legal (rem 65531); counter 16-bit, no wrap beyond rem==0.
//  Unknown opcode with valid len -> DRAIN then ERR. len<4 -> ERR directly (no drain).
//  No timeout: a stalled host holds the FSM in its current state.
// TESTING
//  ADD: A1 00 0C 00 01 00 00 00 FF FF FF FF -> 00 00 00 00 (wrap), err_o=0
//  MUL: B2 00 0C 00 03 00 00 00 05 00 00 00 -> 0F 00 00 00
//  ECHO: EC 00 07 00 61 62 63 -> 61 62 63; EC 00 04 00 -> no output, next frame accepted
//  Reject: 55 00 06 00 AA BB -> both drained, EE emitted, err_o one pulse;
//   A1 00 06 00 11 22 -> EE; A1 00 02 00 -> EE immediately
//  Backpressure: random m_axis_tready during SEND/ECHO -> tdata stable while stalled, no loss/dup
//  Reset: assert rst after 6 bytes of ADD frame -> outputs reset; next full MUL frame correct

Source files
------------

// File: rtl/alu_responder.sv
// alu_responder: byte-stream command responder (opcode/rsvd/len header, echo/add/mul/reject) between uart_rx and uart_tx
module alu_responder #(
  parameter logic [7:0] OP_ECHO  = 8'hEC,
  parameter logic [7:0] OP_ADD   = 8'hA1,
  parameter logic [7:0] OP_MUL   = 8'hB2,
  parameter logic [7:0] ERR_BYTE = 8'hEE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       busy,
  output logic       err_o
);
  typedef enum logic [3:0] {OPC, RSV, LLO, LHI, ECHO, OPND, EXEC, SEND, DRAIN, ERR} state_t;
  state_t state, state_n;
  logic [7:0] opc, len_lo, load_data;
  logic [15:0] rem, len;
  logic [31:0] accum, opnd;
  logic [2:0] cnt;
  logic out_free, load, s_hs;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= OPC;
    else state <= state_n;
  always_comb begin
    len = {s_axis_tdata, len_lo};
    out_free = !m_axis_tvalid || m_axis_tready;
    s_axis_tready = 1'b0;
    state_n = state;
    load = 1'b0;
    load_data = ERR_BYTE;
    case (state)
      OPC: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) state_n = RSV;
      end
      RSV: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) state_n = LLO;
      end
      LLO: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) state_n = LHI;
      end
      LHI: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid)
          state_n = len < 16'd4 ? ERR :
                    opc == OP_ECHO ? (len == 16'd4 ? OPC : ECHO) :
                    ((opc == OP_ADD || opc == OP_MUL) && len >= 16'd8 && len[1:0] == 2'd0) ? OPND : DRAIN;
      end
      ECHO: begin
        s_axis_tready = out_free;
        load = s_axis_tvalid && out_free;
        load_data = s_axis_tdata;
        if (load && rem == 16'd1) state_n = OPC;
      end
      OPND: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && cnt == 3'd3) state_n = EXEC;
      end
      EXEC: state_n = rem == 16'd0 ? SEND : OPND;
      SEND: begin
        load = out_free && !cnt[2];
        load_data = accum[{cnt[1:0], 3'b000} +: 8];
        if (cnt[2] && m_axis_tvalid && m_axis_tready) state_n = OPC;
      end
      DRAIN: begin
        // rem==0 must not swallow the first byte of the next frame
        s_axis_tready = rem != 16'd0;
        if (rem == 16'd0) state_n = ERR;
      end
      ERR: begin
        load = out_free && cnt == 3'd0;
        if (cnt == 3'd1 && m_axis_tvalid && m_axis_tready) state_n = OPC;
      end
      default: state_n = OPC;
    endcase
    s_hs = s_axis_tvalid && s_axis_tready;
    busy = state != OPC;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      opc <= 8'd0;
      len_lo <= 8'd0;
      rem <= 16'd0;
      accum <= 32'd0;
      opnd <= 32'd0;
      cnt <= 3'd0;
      m_axis_tdata <= 8'd0;
      m_axis_tvalid <= 1'b0;
      err_o <= 1'b0;
    end else begin
      if (state == OPC && s_hs) opc <= s_axis_tdata;
      if (state == LLO && s_hs) len_lo <= s_axis_tdata;
      if (state == LHI && s_hs) begin
        rem <= len - 16'd4;
        accum <= opc == OP_MUL ? 32'd1 : 32'd0;
      end else if ((state == ECHO || state == OPND || state == DRAIN) && s_hs) rem <= rem - 16'd1;
      if (state == OPND && s_hs) opnd <= {s_axis_tdata, opnd[31:8]};
      if (state == EXEC) accum <= opc == OP_ADD ? accum + opnd : accum * opnd;
      // cnt counts operand bytes in OPND and loaded response bytes in SEND/ERR
      cnt <= state_n != state ? 3'd0 : cnt + {2'b00, (state == OPND && s_hs) || load};
      if (load) begin
        m_axis_tdata <= load_data;
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready) m_axis_tvalid <= 1'b0;
      err_o <= state_n == ERR && state != ERR;
    end
endmodule
